mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares one mem instance (single port, byte cells, size/zero_ex aware) between two requesters:
//   instruction fetch (port I, read-only, word) and load/store unit (port D, read/write, any size).
// - Sits between the core front-end/LSU and mem; owns every mem control input; one transaction in flight.
// PARAMETERS
// - WIDTH      32     data word width; equals mem WIDTH
// - DEPTH      2**4   mem depth in bytes; address width AW = $clog2(DEPTH)
// - SYNC_READ  0      must match mem SYNC_READ; 1 adds one WAIT cycle to reads
// PORTS
// - clk          in   1      single clock; drives mem wclk and rclk
// - resn         in   1      reset, asynchronous, active-low
// - i_valid      in   1      fetch request valid
// - i_ready      out  1      fetch request accepted this cycle
// - i_addr       in   AW     fetch byte address
// - i_rsp_valid  out  1      fetch response valid, 1-cycle pulse
// - i_rsp_err    out  1      fetch response is an out-of-range error
// - d_valid      in   1      data request valid
// - d_ready      out  1      data request accepted this cycle
// - d_wen        in   1      1 store, 0 load
// - d_size       in   op_enum_dmem_size  BYTE/HALF/TRPL/WORD
// - d_zero_ex    in   1      load zero-extend
// - d_addr       in   AW     data byte address
// - d_wdata      in   WIDTH  store data
// - d_rsp_valid  out  1      data response valid, 1-cycle pulse; also completes stores
// - d_rsp_err    out  1      data response is an out-of-range error
// - rsp_rdata    out  WIDTH  read data for whichever rsp_valid is high
// - mem_req/mem_wen/mem_ren/mem_zero_ex/mem_size/mem_addr/mem_wdata  out  to mem
// - mem_rdata    in   WIDTH  from mem rd_data
// BEHAVIOUR
// - FSM: IDLE -> ACCESS -> [WAIT if SYNC_READ and read] -> RESP -> IDLE.
// - IDLE: if any valid, arbitrate; x_ready = (state==IDLE) & grant_x, combinational, same cycle.
//   On accept, latch owner, wen, size (fetch: WORD, zero_ex=0), zero_ex, addr, wdata. Next state ACCESS.
// - Range check at accept: bytes = 1/2/3/4 by size; addr+bytes > DEPTH is an error.
//   On error: no mem access, go directly to RESP with err=1, rsp_rdata = all ones.
// - ACCESS: mem_req=1, mem_wen=wen, mem_ren=~wen, other mem inputs from the latched registers.
//   Store commits at the edge ending ACCESS. Async-read load captures mem_rdata into rsp_rdata at that edge.
// - WAIT (sync read only): mem_req=1, mem_ren=1 held; rsp_rdata captured at the edge ending WAIT.
// - RESP: owner's rsp_valid=1 for exactly one cycle; rsp_rdata held; store rsp_rdata=0. Next state IDLE.
// - Latency accept->rsp_valid: 2 cycles (async read/store), 3 (sync read), 1 (error).
//   Throughput: at most 1 transaction per 3 cycles (async read/store) or per 4 (sync read).
// - mem_* all 0 outside ACCESS/WAIT; no request is accepted outside IDLE.
// - Requester contract: fields held stable while valid & ~ready; a requester may drop valid before ready.
// - Reset (resn low, any state, mid-transaction included): state IDLE; all outputs 0;
//   latched request discarded, no response issued; last_grant = I.
//   A store reaching its ACCESS edge during reset is not guaranteed.
// - Tie (both valid in IDLE): see CONFIGURATION. A single valid requester is always granted.
// CONFIGURATION
// - MEM_ARB_ROUND_ROBIN_EN defined: tie goes to the port opposite last_grant.
//   last_grant updates on every accept, so D wins the first tie after reset.
// - Undefined: fixed priority, D always wins ties; last_grant unused. I may starve under continuous D traffic.
// TESTING
// - Reset then i_valid only, i_addr=4, mem[7:4]=DE AD BE EF -> i_ready cycle 0; i_rsp_valid cycle 2; rsp_rdata=32'hDEADBEEF.
// - Store D: size=HALF, addr=2, wdata=32'h1234ABCD -> d_rsp_valid 2 cycles after accept.
//   Follow-up WORD load at 0 -> rsp_rdata[31:16]=16'hABCD.
// - Load BYTE addr=5 holding 8'h80: zero_ex=0 -> 32'hFFFFFF80; zero_ex=1 -> 32'h00000080. Repeat with SYNC_READ=1: latency 3.
// - Range error: D WORD addr=DEPTH-2 -> no mem_req pulse; d_rsp_valid+d_rsp_err 1 cycle after accept; rsp_rdata all ones.
// - Ties, both valid held 4 transactions: with ROUND_ROBIN_EN grants D,I,D,I; without grants D,D,D,D.
// - Assert resn low in ACCESS of an I read -> no i_rsp_valid; outputs 0; after release the next tie is granted to D.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg / mem_arbiter_if
//  Description : Size encoding for data-memory accesses and the bundle of
//                requester, response and memory-side signals that connects
//                mem_arbiter to the core front-end, the LSU and the memory.
//                slave  modport : arbiter view (takes requests, drives mem).
//                master modport : surroundings view (requesters + memory).
//  Signals     : i_valid/i_ready/i_addr           fetch request (word read)
//                i_rsp_valid/i_rsp_err            fetch response
//                d_valid/d_ready/d_wen/d_size/
//                d_zero_ex/d_addr/d_wdata         load/store request
//                d_rsp_valid/d_rsp_err            load/store response
//                rsp_rdata                        read data for either response
//                mem_req/mem_wen/mem_ren/mem_zero_ex/mem_size/mem_addr/
//                mem_wdata                        memory control (arbiter-owned)
//                mem_rdata                        memory read data
//  Revision    : 1.0 - initial release
// ============================================================================

package mem_arbiter_pkg;

    // Access size; the byte count of an access is the encoding plus one.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        TRPL = 2'd2,
        WORD = 2'd3
    } op_enum_dmem_size;

endpackage

interface mem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    // Fetch port
    logic                               i_valid;
    logic                               i_ready;
    logic [AW-1:0]                      i_addr;
    logic                               i_rsp_valid;
    logic                               i_rsp_err;

    // Load/store port
    logic                               d_valid;
    logic                               d_ready;
    logic                               d_wen;
    mem_arbiter_pkg::op_enum_dmem_size  d_size;
    logic                               d_zero_ex;
    logic [AW-1:0]                      d_addr;
    logic [WIDTH-1:0]                   d_wdata;
    logic                               d_rsp_valid;
    logic                               d_rsp_err;

    // Shared response data
    logic [WIDTH-1:0]                   rsp_rdata;

    // Memory side
    logic                               mem_req;
    logic                               mem_wen;
    logic                               mem_ren;
    logic                               mem_zero_ex;
    mem_arbiter_pkg::op_enum_dmem_size  mem_size;
    logic [AW-1:0]                      mem_addr;
    logic [WIDTH-1:0]                   mem_wdata;
    logic [WIDTH-1:0]                   mem_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rsp_valid, i_rsp_err,
        input  d_valid, d_wen, d_size, d_zero_ex, d_addr, d_wdata,
        output d_ready, d_rsp_valid, d_rsp_err,
        output rsp_rdata,
        output mem_req, mem_wen, mem_ren, mem_zero_ex, mem_size, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rsp_valid, i_rsp_err,
        output d_valid, d_wen, d_size, d_zero_ex, d_addr, d_wdata,
        input  d_ready, d_rsp_valid, d_rsp_err,
        input  rsp_rdata,
        input  mem_req, mem_wen, mem_ren, mem_zero_ex, mem_size, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port, byte-addressed memory between the
//                instruction fetch port (I, word reads only) and the
//                load/store port (D, any size, read or write). One
//                transaction is in flight at a time:
//                  IDLE -> ACCESS -> [WAIT, sync-read loads] -> RESP -> IDLE
//                Requests whose bytes run past DEPTH skip the memory and
//                answer one cycle after accept with err=1, data all ones.
//  Parameters  : WIDTH     data width (must equal memory WIDTH)
//                DEPTH     memory depth in bytes
//                SYNC_READ 1 when the memory registers its read data
//  Ports       : clk       clock (also clocks the memory)
//                resn      asynchronous active-low reset
//                bus       mem_arbiter_if.slave - requests, responses, memory
//  Config      : MEM_ARB_ROUND_ROBIN_EN defined  - ties alternate, starting
//                with D after reset. Undefined - D always wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================

module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2**4,
    parameter int SYNC_READ = 0
) (
    input  wire logic       clk,
    input  wire logic       resn,
    mem_arbiter_if.slave    bus
);
    import mem_arbiter_pkg::*;

    localparam int AW = $clog2(DEPTH);
    // Range-check arithmetic is done a few bits wider than the address so
    // addr + 4 can never wrap.
    localparam int SW = AW + 3;

    localparam logic [SW-1:0] c_depth   = SW'(DEPTH);
    localparam bit            c_sync    = (SYNC_READ != 0);

    localparam logic [1:0]    c_idle    = 2'd0;
    localparam logic [1:0]    c_access  = 2'd1;
    localparam logic [1:0]    c_wait    = 2'd2;
    localparam logic [1:0]    c_resp    = 2'd3;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_owner_d;      // 1: D owns the transaction, 0: I
    logic               r_wen;
    op_enum_dmem_size   r_size;
    logic               r_zero_ex;
    logic [AW-1:0]      r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_err;
    logic [WIDTH-1:0]   r_rdata;

    // ------------------------------------------------------------------
    // Arbitration and request mux
    // ------------------------------------------------------------------
    logic               w_tie_to_d;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_accept_i;
    logic               w_accept_d;
    logic               w_accept;

    op_enum_dmem_size   w_req_size;
    logic [1:0]         w_req_size_bits;
    logic               w_req_wen;
    logic               w_req_zero_ex;
    logic [AW-1:0]      w_req_addr;
    logic [WIDTH-1:0]   w_req_wdata;
    logic [SW-1:0]      w_req_end;
    logic               w_req_err;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the most recent accept (1: D). Reset value I makes
    // D the winner of the first tie after reset.
    logic               r_last_d;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_last_d <= 1'b0;
        end else if (w_accept) begin
            r_last_d <= w_grant_d;
        end
    end
`endif

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_tie_to_d = ~r_last_d;
`else
        w_tie_to_d = 1'b1;
`endif
        // A lone requester always wins; a tie is settled by w_tie_to_d.
        w_grant_d  = bus.d_valid & (~bus.i_valid | w_tie_to_d);
        w_grant_i  = bus.i_valid & ~w_grant_d;

        // Ready is gated by resn so nothing looks accepted while reset is
        // held, even though the state already reads IDLE.
        w_accept_i = resn & (r_state == c_idle) & w_grant_i;
        w_accept_d = resn & (r_state == c_idle) & w_grant_d;
        w_accept   = w_accept_i | w_accept_d;

        // Fetches are always sign-agnostic word reads.
        w_req_size      = w_grant_d ? bus.d_size    : WORD;
        w_req_wen       = w_grant_d ? bus.d_wen     : 1'b0;
        w_req_zero_ex   = w_grant_d ? bus.d_zero_ex : 1'b0;
        w_req_addr      = w_grant_d ? bus.d_addr    : bus.i_addr;
        w_req_wdata     = w_grant_d ? bus.d_wdata   : '0;

        // Last byte touched is addr + size; the access is legal while
        // addr + (size + 1) stays within DEPTH.
        w_req_size_bits = w_req_size;
        w_req_end       = SW'(w_req_addr) + SW'(w_req_size_bits) + SW'(1);
        w_req_err       = (w_req_end > c_depth);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    // Out-of-range requests never touch the memory.
                    w_state_nxt = w_req_err ? c_resp : c_access;
                end
            end
            c_access: begin
                w_state_nxt = (c_sync && !r_wen) ? c_wait : c_resp;
            end
            c_wait: begin
                w_state_nxt = c_resp;
            end
            c_resp: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_owner_d <= 1'b0;
            r_wen     <= 1'b0;
            r_size    <= BYTE;
            r_zero_ex <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else if (w_accept) begin
            r_owner_d <= w_grant_d;
            r_wen     <= w_req_wen;
            r_size    <= w_req_size;
            r_zero_ex <= w_req_zero_ex;
            r_addr    <= w_req_addr;
            r_wdata   <= w_req_wdata;
            r_err     <= w_req_err;
            // Errors answer all ones; stores answer zero; loads overwrite
            // this with the memory data before RESP.
            r_rdata   <= w_req_err ? '1 : '0;
        end else if ((r_state == c_access) && !r_wen && !c_sync) begin
            r_rdata   <= bus.mem_rdata;
        end else if (r_state == c_wait) begin
            r_rdata   <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.i_ready     = w_accept_i;
        bus.d_ready     = w_accept_d;
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_err   = 1'b0;
        bus.d_rsp_valid = 1'b0;
        bus.d_rsp_err   = 1'b0;
        bus.rsp_rdata   = r_rdata;
        bus.mem_req     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_zero_ex = 1'b0;
        bus.mem_size    = BYTE;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        case (r_state)
            c_access: begin
                // The memory commits a store on the edge that ends this cycle.
                bus.mem_req     = 1'b1;
                bus.mem_wen     = r_wen;
                bus.mem_ren     = ~r_wen;
                bus.mem_zero_ex = r_zero_ex;
                bus.mem_size    = r_size;
                bus.mem_addr    = r_addr;
                bus.mem_wdata   = r_wdata;
            end
            c_wait: begin
                // Hold the read request while the registered data arrives.
                bus.mem_req     = 1'b1;
                bus.mem_ren     = 1'b1;
                bus.mem_zero_ex = r_zero_ex;
                bus.mem_size    = r_size;
                bus.mem_addr    = r_addr;
            end
            c_resp: begin
                bus.i_rsp_valid = ~r_owner_d;
                bus.i_rsp_err   = ~r_owner_d & r_err;
                bus.d_rsp_valid = r_owner_d;
                bus.d_rsp_err   = r_owner_d & r_err;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Holds a behavioural
//                byte memory per DUT (async-read and sync-read instances)
//                and a golden byte array with a transaction-level model of
//                arbitration, range errors, latency and response data.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk;
    logic resn;
    logic mem_init;

    mem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus   ();
    mem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus_s ();

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_READ(0)) u_dut (
        .clk  (clk),
        .resn (resn),
        .bus  (bus)
    );

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_READ(1)) u_dut_sync (
        .clk  (clk),
        .resn (resn),
        .bus  (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory models (little-endian byte cells, size/zero_ex aware)
    // ------------------------------------------------------------------
    logic [7:0]  mem_a [DEPTH];
    logic [7:0]  mem_s [DEPTH];
    logic [31:0] raw_a;
    logic [31:0] raw_s;
    logic [31:0] rdata_s;

    function automatic logic [7:0] init_byte(input int k);
        case (k)
            4:       return 8'hEF;
            5:       return 8'hBE;
            6:       return 8'hAD;
            7:       return 8'hDE;
            default: return 8'(k * 29 + 7);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit zx);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = raw & mask;
        if (!zx && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    always_comb begin
        raw_a = '0;
        raw_s = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(bus.mem_addr) + k < DEPTH)   raw_a[8*k +: 8] = mem_a[int'(bus.mem_addr) + k];
            if (int'(bus_s.mem_addr) + k < DEPTH) raw_s[8*k +: 8] = mem_s[int'(bus_s.mem_addr) + k];
        end
        bus.mem_rdata   = (bus.mem_req && bus.mem_ren)
                        ? extend(raw_a, int'(bus.mem_size) + 1, bus.mem_zero_ex) : '0;
        bus_s.mem_rdata = rdata_s;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_a[k] <= init_byte(k);
                mem_s[k] <= init_byte(k);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.mem_req && bus.mem_wen && k <= int'(bus.mem_size)
                    && int'(bus.mem_addr) + k < DEPTH)
                    mem_a[int'(bus.mem_addr) + k] <= bus.mem_wdata[8*k +: 8];
                if (bus_s.mem_req && bus_s.mem_wen && k <= int'(bus_s.mem_size)
                    && int'(bus_s.mem_addr) + k < DEPTH)
                    mem_s[int'(bus_s.mem_addr) + k] <= bus_s.mem_wdata[8*k +: 8];
            end
        end
        if (bus_s.mem_req && bus_s.mem_ren)
            rdata_s <= extend(raw_s, int'(bus_s.mem_size) + 1, bus_s.mem_zero_ex);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Requester state and transaction-level reference model
    // ------------------------------------------------------------------
    bit               pi_v;
    logic [AW-1:0]    pi_addr;
    bit               pd_v;
    bit               pd_wen;
    op_enum_dmem_size pd_size;
    bit               pd_zx;
    logic [AW-1:0]    pd_addr;
    logic [31:0]      pd_wdata;
    bit               hold;

    logic [7:0]  gold [DEPTH];
    int          cyc;
    bit          last_d;        // model: last accept went to D
    bit          ob_pend;
    bit          ob_d;
    bit          ob_err;
    int          ob_acc;
    int          ob_due;
    logic [31:0] ob_rdata;

    // Observed-from-DUT bookkeeping for directed checks
    int          dut_acc;
    int          last_lat;
    logic [31:0] last_rdata;
    logic        last_err;
    bit          dut_grants[$];

    function automatic logic [31:0] gold_read(input int a, input int nb, input bit zx);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < nb; k++) v = v + (32'(gold[a + k]) << (8 * k));
        if (!zx && gold[a + nb - 1][7]) v = v | ~((nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1));
        return v;
    endfunction

    task automatic model_reset();
        ob_pend = 1'b0;
        last_d  = 1'b0;
    endtask

    // One clock cycle: drive requesters, then compare against the model.
    task automatic step();
        bit          free;
        bit          tie_d;
        bit          gi;
        bit          gd;
        bit          exp_iv;
        bit          exp_dv;
        bit          exp_mreq;
        int          nb;
        int          a;
        bit          wen;
        bit          zx;
        @(negedge clk);
        bus.i_valid   = pi_v;
        bus.i_addr    = pi_addr;
        bus.d_valid   = pd_v;
        bus.d_wen     = pd_wen;
        bus.d_size    = pd_size;
        bus.d_zero_ex = pd_zx;
        bus.d_addr    = pd_addr;
        bus.d_wdata   = pd_wdata;
        #1;
        cyc++;

        free  = !ob_pend;
        tie_d = RR_EN ? !last_d : 1'b1;
        gd    = free && pd_v && (!pi_v || tie_d);
        gi    = free && pi_v && !gd;
        check_val("i_ready", 32'(bus.i_ready), 32'(gi));
        check_val("d_ready", 32'(bus.d_ready), 32'(gd));

        exp_mreq = ob_pend && !ob_err && (cyc > ob_acc) && (cyc < ob_due);
        check_val("mem_req", 32'(bus.mem_req), 32'(exp_mreq));

        exp_iv = ob_pend && (ob_due == cyc) && !ob_d;
        exp_dv = ob_pend && (ob_due == cyc) && ob_d;
        check_val("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(exp_iv));
        check_val("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(exp_dv));
        if (exp_iv || exp_dv) begin
            check_val("rsp_err", 32'(ob_d ? bus.d_rsp_err : bus.i_rsp_err), 32'(ob_err));
            check_val("rsp_rdata", bus.rsp_rdata, ob_rdata);
            ob_pend = 1'b0;
        end

        // Observed DUT behaviour for directed checks
        if (bus.d_ready) begin dut_acc = cyc; dut_grants.push_back(1'b1); end
        else if (bus.i_ready) begin dut_acc = cyc; dut_grants.push_back(1'b0); end
        if (bus.i_rsp_valid || bus.d_rsp_valid) begin
            last_lat   = cyc - dut_acc;
            last_rdata = bus.rsp_rdata;
            last_err   = bus.i_rsp_err | bus.d_rsp_err;
        end

        if (gi || gd) begin
            if (gd) begin nb = int'(pd_size) + 1; wen = pd_wen; zx = pd_zx; a = int'(pd_addr); end
            else    begin nb = 4;                 wen = 1'b0;   zx = 1'b0;  a = int'(pi_addr); end
            ob_pend = 1'b1;
            ob_d    = gd;
            ob_acc  = cyc;
            if (a + nb > DEPTH) begin
                ob_err   = 1'b1;
                ob_rdata = 32'hFFFF_FFFF;
                ob_due   = cyc + 1;
            end else begin
                ob_err = 1'b0;
                ob_due = cyc + 2;
                if (wen) begin
                    for (int k = 0; k < nb; k++) gold[a + k] = pd_wdata[8*k +: 8];
                    ob_rdata = 32'h0;
                end else begin
                    ob_rdata = gold_read(a, nb, zx);
                end
            end
            last_d = gd;
            if (!hold) begin
                if (gd) pd_v = 1'b0;
                else    pi_v = 1'b0;
            end
        end
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((pi_v || pd_v || ob_pend) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check_val("drain_timeout", 32'(n), 32'(0));
    endtask

    task automatic d_req(input bit wen, input op_enum_dmem_size sz, input bit zx,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
        pd_v = 1'b1; pd_wen = wen; pd_size = sz; pd_zx = zx; pd_addr = addr; pd_wdata = wd;
        drain(20);
    endtask

    // Single D transaction on the sync-read instance, measured in cycles.
    task automatic sync_txn(input string tag, input bit wen, input op_enum_dmem_size sz,
                            input bit zx, input logic [AW-1:0] addr, input logic [31:0] wd,
                            input int exp_lat, input logic [31:0] exp_rd);
        int lat;
        bit seen;
        @(negedge clk);
        bus_s.d_valid = 1'b1; bus_s.d_wen = wen; bus_s.d_size = sz;
        bus_s.d_zero_ex = zx; bus_s.d_addr = addr; bus_s.d_wdata = wd;
        #1;
        check_val({tag, "_ready"}, 32'(bus_s.d_ready), 32'd1);
        @(negedge clk);
        bus_s.d_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            #1;
            if (bus_s.d_rsp_valid) seen = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        check_val({tag, "_lat"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        check_val({tag, "_rdata"}, bus_s.rsp_rdata, exp_rd);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        resn = 1'b0; mem_init = 1'b1; hold = 1'b0; cyc = 0;
        pi_v = 0; pi_addr = '0; pd_v = 0; pd_wen = 0; pd_size = BYTE; pd_zx = 0;
        pd_addr = '0; pd_wdata = '0; dut_acc = 0; last_lat = 0; last_rdata = '0; last_err = 0;
        bus.i_valid = 1'b1; bus.i_addr = '0; bus.d_valid = 1'b1; bus.d_wen = 1'b0;
        bus.d_size = WORD; bus.d_zero_ex = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus_s.i_valid = 1'b0; bus_s.i_addr = '0; bus_s.d_valid = 1'b0; bus_s.d_wen = 1'b0;
        bus_s.d_size = BYTE; bus_s.d_zero_ex = 1'b0; bus_s.d_addr = '0; bus_s.d_wdata = '0;
        for (int k = 0; k < DEPTH; k++) gold[k] = init_byte(k);
        model_reset();

        // Reset state: everything quiet even with both requesters valid
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_i_ready", 32'(bus.i_ready), 32'd0);
        check_val("rst_d_ready", 32'(bus.d_ready), 32'd0);
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_rsp_valid", 32'(bus.i_rsp_valid | bus.d_rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk);
        resn = 1'b1; mem_init = 1'b0; bus.i_valid = 1'b0; bus.d_valid = 1'b0;

        // Fetch from address 4
        pi_v = 1'b1; pi_addr = 4'd4;
        drain(20);
        check_val("fetch_lat", 32'(last_lat), 32'd2);
        check_val("fetch_data", last_rdata, 32'hDEADBEEF);

        // Half store then word load
        d_req(1'b1, HALF, 1'b0, 4'd2, 32'h1234ABCD);
        check_val("store_lat", 32'(last_lat), 32'd2);
        check_val("store_rdata", last_rdata, 32'd0);
        d_req(1'b0, WORD, 1'b0, 4'd0, 32'h0);
        check_val("load_hi16", last_rdata >> 16, 32'h0000ABCD);

        // Byte loads with and without zero extension
        d_req(1'b1, BYTE, 1'b0, 4'd5, 32'h00000080);
        d_req(1'b0, BYTE, 1'b0, 4'd5, 32'h0);
        check_val("ldb_sext", last_rdata, 32'hFFFFFF80);
        d_req(1'b0, BYTE, 1'b1, 4'd5, 32'h0);
        check_val("ldb_zext", last_rdata, 32'h00000080);

        // Range error: WORD at DEPTH-2
        d_req(1'b0, WORD, 1'b0, 4'(DEPTH - 2), 32'h0);
        check_val("err_lat", 32'(last_lat), 32'd1);
        check_val("err_flag", 32'(last_err), 32'd1);
        check_val("err_rdata", last_rdata, 32'hFFFFFFFF);
        d_req(1'b0, TRPL, 1'b0, 4'(DEPTH - 3), 32'h0);
        check_val("edge_ok", 32'(last_err), 32'd0);

        // Reset in ACCESS of a fetch
        pi_v = 1'b1; pi_addr = 4'd8;
        step();
        @(negedge clk);
        resn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("midrst_i_ready", 32'(bus.i_ready), 32'd0);
            check_val("midrst_out", 32'({bus.i_rsp_valid, bus.d_rsp_valid, bus.mem_req,
                                         bus.mem_ren, bus.mem_wen}), 32'd0);
            check_val("midrst_rdata", bus.rsp_rdata, 32'd0);
            @(negedge clk);
        end
        resn = 1'b1; bus.i_valid = 1'b0; pi_v = 1'b0;
        model_reset();

        // Tie: both valid held for four transactions
        dut_grants.delete();
        pi_v = 1'b1; pi_addr = 4'd8;
        pd_v = 1'b1; pd_wen = 1'b0; pd_size = WORD; pd_zx = 1'b0; pd_addr = 4'd0;
        hold = 1'b1;
        for (int n = 0; n < 40 && dut_grants.size() < 4; n++) step();
        hold = 1'b0; pi_v = 1'b0; pd_v = 1'b0;
        drain(20);
        check_val("tie_count", 32'(dut_grants.size()), 32'd4);
        for (int n = 0; n < 4 && n < dut_grants.size(); n++)
            check_val($sformatf("tie_grant%0d", n), 32'(dut_grants[n]),
                      32'(RR_EN ? (n % 2 == 0) : 1'b1));

        // Randomized traffic from both requesters
        for (int n = 0; n < 500; n++) begin
            if (!pi_v && $urandom_range(0, 2) == 0) begin
                pi_v = 1'b1; pi_addr = 4'($urandom_range(0, DEPTH - 1));
            end
            if (!pd_v && $urandom_range(0, 1) == 0) begin
                pd_v     = 1'b1;
                pd_wen   = 1'($urandom_range(0, 1));
                pd_size  = op_enum_dmem_size'($urandom_range(0, 3));
                pd_zx    = 1'($urandom_range(0, 1));
                pd_addr  = 4'($urandom_range(0, DEPTH - 1));
                pd_wdata = $urandom;
            end
            step();
        end
        drain(40);

        // Sync-read instance
        sync_txn("s_store", 1'b1, BYTE, 1'b0, 4'd5, 32'h00000080, 2, 32'h0);
        sync_txn("s_ldb_sext", 1'b0, BYTE, 1'b0, 4'd5, 32'h0, 3, 32'hFFFFFF80);
        sync_txn("s_ldb_zext", 1'b0, BYTE, 1'b1, 4'd5, 32'h0, 3, 32'h00000080);
        sync_txn("s_err", 1'b0, WORD, 1'b0, 4'(DEPTH - 2), 32'h0, 1, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
